aes_round_seq: RTL and testbench

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_pkg.sv | 133 +++++++++++++
 rtl/aes_round_seq.sv | 141 ++++++++++++++
 tb/tb_aes_round_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES-128 byte, column and key-schedule primitives. Byte i of a 128-bit value
// sits at bits [8i+7:8i]; byte i is state row i%4, column i/4.
package aes_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c - r + 4) % 4)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c +: 8]      = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c + 8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c + 8 +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c +: 8]      = gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9);
      o[32*c + 8 +: 8]  = gf_mul(a0, 8'd9) ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13);
      o[32*c + 16 +: 8] = gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9) ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11);
      o[32*c + 24 +: 8] = gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9) ^ gf_mul(a3, 8'd14);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte 0 is the low byte, so rotating bytes left moves the low byte to the top.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_seq.sv
// Iterative AES-128 engine: expands the key into an 11-entry round-key table,
// then encrypts or decrypts one block at one round per clock.
module aes_round_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         key_ok,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [3:0]     rc;
  logic           mode;
  logic [127:0]   s;
  logic [127:0]   rk [0:10];
  logic [127:0]   rk_prev;
  logic [127:0]   rk_next;
  logic [127:0]   round_res;
  logic [127:0]   enc_core;
  logic [127:0]   dec_core;
  logic [31:0]    kt;
  logic           key_acc;
  logic           data_acc;

  assign key_acc  = key_valid && key_ready;
  assign data_acc = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (key_acc) state_next = KEXP;
             else if (data_acc) state_next = ROUND;
      KEXP:  if (rc == 4'd10) state_next = IDLE;
      ROUND: if (rc == 4'd10) state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state == IDLE);
    in_ready  = (state == IDLE) && key_ok && !key_valid;
    busy      = (state != IDLE);
  end

  // Key schedule step: derive rk[rc] from rk[rc-1].
  always_comb begin
    rk_prev = rk[rc - 4'd1];
    kt      = sub_word(rot_word(rk_prev[127:96])) ^ {24'h0, rcon(rc)};
    rk_next[31:0]   = rk_prev[31:0] ^ kt;
    rk_next[63:32]  = rk_prev[63:32] ^ rk_next[31:0];
    rk_next[95:64]  = rk_prev[95:64] ^ rk_next[63:32];
    rk_next[127:96] = rk_prev[127:96] ^ rk_next[95:64];
  end

  // Decryption walks the table backwards and ends on rk[0] at rc == 10.
  always_comb begin
    enc_core = shift_rows(sub_bytes(s));
    dec_core = add_round_key(inv_sub_bytes(inv_shift_rows(s)), rk[4'd10 - rc]);
    if (mode)
      round_res = (rc == 4'd10) ? dec_core : inv_mix_columns(dec_core);
    else
      round_res = add_round_key((rc == 4'd10) ? enc_core : mix_columns(enc_core), rk[rc]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc        <= 4'd0;
      key_ok    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 128'h0;
    end else begin
      case (state)
        IDLE: begin
          if (key_acc) begin
            rc     <= 4'd1;
            key_ok <= 1'b0;
          end else if (data_acc) begin
            rc <= 4'd1;
          end
        end
        KEXP: begin
          if (rc == 4'd10) begin
            key_ok <= 1'b1;
            rc     <= 4'd0;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        ROUND: begin
          if (rc == 4'd10) begin
            out_data  <= round_res;
            out_valid <= 1'b1;
            rc        <= 4'd0;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: rc <= 4'd0;
      endcase
    end
  end

  // Key table and working state carry no reset; key_ok gates their use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (key_acc) begin
          rk[0] <= key;
        end else if (data_acc) begin
          mode <= in_decrypt;
          s    <= add_round_key(in_data, in_decrypt ? rk[10] : rk[0]);
        end
      end
      KEXP:  rk[rc] <= rk_next;
      ROUND: s <= round_res;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq using FIPS-197 C.1 and Appendix B vectors,
// byte-reversed so that FIPS byte 0 lands in bits [7:0].
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         key_ok;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT1  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CT1  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] KEY2 = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] PT2  = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] CT2  = 128'h320b6a19978511dcfb09dc021d842539;

  aes_round_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .key_ok     (key_ok),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a key for one edge, then count cycles until key_ok rises.
  task automatic load_key(input logic [127:0] k, output int n);
    key       = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    n = 0;
    while (key_ok !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Offer one block for one edge, then count cycles until out_valid rises.
  task automatic run_block(input logic [127:0] d, input logic dec,
                           output logic acc, output int n, output logic [127:0] res);
    in_data    = d;
    in_decrypt = dec;
    in_valid   = 1'b1;
    acc        = in_ready;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    res = out_data;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key = '0; in_valid = 1'b1; in_decrypt = 1'b0;
    in_data = PT1; out_ready = 1'b0;
    tick(); tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (key_ok !== 1'b0) $display("FAIL reset_key_ok got %b want 0", key_ok); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 128'h0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
    total_cnt++; if (key_ready !== 1'b1) $display("FAIL reset_key_ready got %b want 1", key_ready); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass_cnt++;
  endtask

  task automatic test_no_key_data();
    logic seen;
    seen = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (seen !== 1'b0) $display("FAIL nokey_data_accepted got %b want 0", seen); else pass_cnt++;
  endtask

  task automatic test_key_load();
    int n;
    key       = KEY1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1 || key_ready !== 1'b0 || key_ok !== 1'b0)
      $display("FAIL kexp_flags got busy=%b key_ready=%b key_ok=%b want 1/0/0", busy, key_ready, key_ok);
    else pass_cnt++;
    n = 0;
    while (key_ok !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++; if (n != 10) $display("FAIL key_ok_latency got %0d want 10", n); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL post_kexp got busy=%b in_ready=%b want 0/1", busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_encrypt();
    logic acc; int n; logic [127:0] res;
    run_block(PT1, 1'b0, acc, n, res);
    total_cnt++; if (acc !== 1'b1) $display("FAIL enc_accept got %b want 1", acc); else pass_cnt++;
    total_cnt++; if (n != 10) $display("FAIL enc_latency got %0d want 10", n); else pass_cnt++;
    total_cnt++; if (res !== CT1) $display("FAIL enc_data got %h want %h", res, CT1); else pass_cnt++;
    consume();
    total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL enc_handshake got out_valid=%b busy=%b want 0/0", out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_decrypt();
    logic acc; int n; logic [127:0] res;
    run_block(CT1, 1'b1, acc, n, res);
    total_cnt++; if (n != 10) $display("FAIL dec_latency got %0d want 10", n); else pass_cnt++;
    total_cnt++; if (res !== PT1) $display("FAIL dec_data got %h want %h", res, PT1); else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure();
    logic acc; int n; logic [127:0] res;
    run_block(PT1, 1'b0, acc, n, res);
    total_cnt++; if (res !== CT1) $display("FAIL bp_data got %h want %h", res, CT1); else pass_cnt++;
    // Offers made while a result waits must be ignored.
    key = KEY2; key_valid = 1'b1; in_data = PT2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== CT1)
        $display("FAIL bp_hold cycle %0d got out_valid=%b data=%h want 1/%h", i, out_valid, out_data, CT1);
      else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b0 || key_ready !== 1'b0)
        $display("FAIL bp_ready cycle %0d got in_ready=%b key_ready=%b want 0/0", i, in_ready, key_ready);
      else pass_cnt++;
    end
    key_valid = 1'b0; in_valid = 1'b0;
    consume();
    total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || key_ok !== 1'b1)
      $display("FAIL bp_release got out_valid=%b busy=%b key_ready=%b key_ok=%b want 0/0/1/1",
               out_valid, busy, key_ready, key_ok);
    else pass_cnt++;
  endtask

  task automatic test_key_priority();
    int n; logic acc;
    key = KEY2; key_valid = 1'b1;
    in_data = PT2; in_decrypt = 1'b0; in_valid = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL prio_in_ready got %b want 0", in_ready); else pass_cnt++;
    tick();
    key_valid = 1'b0;
    total_cnt++; if (key_ok !== 1'b0 || busy !== 1'b1)
      $display("FAIL prio_kexp got key_ok=%b busy=%b want 0/1", key_ok, busy);
    else pass_cnt++;
    n = 0;
    while (key_ok !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total_cnt++; if (n != 10) $display("FAIL prio_key_latency got %0d want 10", n); else pass_cnt++;
    acc = in_ready;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (acc !== 1'b1 || busy !== 1'b1)
      $display("FAIL prio_data_accept got in_ready=%b busy=%b want 1/1", acc, busy);
    else pass_cnt++;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    total_cnt++; if (n != 10 || out_data !== CT2)
      $display("FAIL prio_result got lat=%0d data=%h want 10/%h", n, out_data, CT2);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back();
    int acc_t[$]; int outs; logic acc; int n;
    outs = 0;
    out_ready = 1'b1; in_data = PT2; in_decrypt = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      acc = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        outs++;
        total_cnt++; if (out_data !== CT2)
          $display("FAIL b2b_data out %0d got %h want %h", outs, out_data, CT2);
        else pass_cnt++;
      end
      tick();
      if (acc) acc_t.push_back(i);
    end
    in_valid = 1'b0;
    total_cnt++; if (acc_t.size() != 4 || outs != 3)
      $display("FAIL b2b_counts got accepts=%0d outputs=%0d want 4/3", acc_t.size(), outs);
    else pass_cnt++;
    total_cnt++; if (acc_t.size() < 2 || acc_t[1] - acc_t[0] != 12)
      $display("FAIL b2b_interval got %0d want 12", acc_t.size() < 2 ? -1 : acc_t[1] - acc_t[0]);
    else pass_cnt++;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0 || out_data !== CT2)
      $display("FAIL b2b_drain got busy=%b data=%h want 0/%h", busy, out_data, CT2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_round();
    logic seen; int n; logic acc; logic [127:0] res;
    in_data = PT2; in_decrypt = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || key_ok !== 1'b0 || out_valid !== 1'b0 || out_data !== 128'h0)
      $display("FAIL midrst_state got busy=%b key_ok=%b out_valid=%b data=%h want 0/0/0/0",
               busy, key_ok, out_valid, out_data);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (seen !== 1'b0) $display("FAIL midrst_quiet got activity=%b want 0", seen); else pass_cnt++;
    load_key(KEY1, n);
    total_cnt++; if (n != 10) $display("FAIL reload_key_latency got %0d want 10", n); else pass_cnt++;
    run_block(PT1, 1'b0, acc, n, res);
    total_cnt++; if (acc !== 1'b1 || res !== CT1)
      $display("FAIL reload_enc got accept=%b data=%h want 1/%h", acc, res, CT1);
    else pass_cnt++;
    consume();
  endtask

  initial begin
    test_reset();
    test_no_key_data();
    test_key_load();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_key_priority();
    test_back_to_back();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
